spi_peripheral_ht16d35a_rx: RTL
===============================

// Module: spi_peripheral_ht16d35a_rx
// PURPOSE
//  Receive-side model of the HT16D35A 3-wire SPI target: oversamples sck/dio/cs_n on the system clock.
//  Reassembles MSB-first bytes and reports each byte, frame boundaries and timing violations.
//  Sits opposite the 3-wire SPI controller: as a loopback checker on-chip, or as an FPGA-hosted display-driver stand-in.
//  Write-only; read mode (target driving dio) is not supported.
// PARAMETERS
//  MAX_BYTES    8    bytes per frame tracked; index/count width = $clog2(MAX_BYTES+1)
//  CLK_2us      100  system clocks in 2us (minimum sck-high gap after each byte, and last edge to CS release)
//  SYNC_STAGES  2    flops in each input synchroniser (>=2)
// PORTS
//  clk           in   1      system clock
//  reset         in   1      asynchronous, active-low reset
//  sck           in   1      SPI clock from controller, idles high, sampled on rising edge
//  dio           in   1      SPI data from controller
//  cs_n          in   1      chip select, active low
//  rx_data       out  8      last completed byte
//  rx_valid      out  1      1-cycle pulse, rx_data/rx_index valid
//  rx_index      out  CW     byte position in frame, 0 = first byte (saturates at MAX_BYTES)
//  frame_done    out  1      1-cycle pulse on synchronised cs_n rise after an active frame
//  frame_count   out  CW     complete bytes in the finished frame (valid with frame_done)
//  gap_err       out  1      sticky: inter-byte or CS-hold gap shorter than CLK_2us
//  partial_err   out  1      sticky: CS released with 1..7 bits of an unfinished byte
//  overrun_err   out  1      sticky: more than MAX_BYTES bytes in one frame
//  err_clear     in   1      clears all sticky error flags (same-cycle set wins)
// BEHAVIOUR
//  Reset values
//   - All outputs 0. State S_WAIT_CS_HIGH, all counters 0, synchroniser flops preset to 1.
//  Input conditioning
//   - sck, dio and cs_n pass through SYNC_STAGES flops.
//   - Rising edge = sync'd sck prev 0, now 1. Falling edge is the inverse.
//   - dio is sampled from its synchroniser on the rising-edge cycle; edges while cs_n high are ignored.
//  States
//   - S_WAIT_CS_HIGH: entered from reset; waits for sync'd cs_n==1, then goes to S_IDLE.
//     A frame already in progress at reset release is ignored in full.
//   - S_IDLE: sync'd cs_n falling -> S_SHIFT. Clear bit_cnt, byte_idx and gap_cnt.
//   - S_SHIFT: on each rising edge, shreg <= {shreg[6:0],dio} and bit_cnt++.
//     On the 8th edge:
//       - next cycle rx_data = byte, rx_valid = 1, rx_index = byte_idx;
//       - byte_idx++ (saturating at MAX_BYTES); gap_cnt <= 0; -> S_GAP.
//   - S_GAP: gap_cnt++ each cycle, saturating at CLK_2us.
//     - Falling edge: if gap_cnt < CLK_2us set gap_err; -> S_SHIFT for the next byte.
//     - cs_n release: apply the same gap_err check, then end the frame.
//  Frame end (sync'd cs_n rises, any state except S_WAIT_CS_HIGH/S_IDLE)
//   - frame_done pulse; frame_count = byte_idx; -> S_IDLE.
//   - If in S_SHIFT with bit_cnt in 1..7: set partial_err and discard the bits.
//   - If in S_SHIFT with bit_cnt == 0 (CS released before any bit): no error.
//  Overrun
//   - On the (MAX_BYTES+1)th byte: rx_valid still pulses, rx_index = MAX_BYTES, overrun_err set.
//  Latency
//   - Raw sck rise to rx_valid = SYNC_STAGES+2 clocks.
//   - Raw cs_n rise to frame_done = SYNC_STAGES+2 clocks.
//  Simultaneous events
//   - A byte completes on the same cycle cs_n rises: rx_valid first, frame_done the next cycle, count includes that byte.
//   - A sticky error sets on the same cycle as err_clear: the error flag stays set.
//  Inputs must be stable for >=2 clk per sck half-period (controller CLK_DIV>=4 satisfies this).
// TESTING
//  T1: cs_n low, bytes 0xA5 then 0x3C, 2us gaps, cs_n high
//      -> rx_valid x2 with (0xA5, idx 0) and (0x3C, idx 1); frame_done with frame_count = 2; no errors.
//  T2: same frame, inter-byte gap CLK_2us-5 clocks
//      -> both bytes delivered, gap_err = 1; err_clear -> gap_err = 0.
//  T3: cs_n low, 5 bits of 0b10110, cs_n high
//      -> no rx_valid, partial_err = 1, frame_done with frame_count = 0.
//  T4: MAX_BYTES+1 = 9 bytes 0x01..0x09
//      -> 9 rx_valid pulses, 9th with rx_index = 8; overrun_err = 1; frame_count = 8.
//  T5: reset asserted mid-byte of 0xFF, released while cs_n still low, then remaining bits sent
//      -> no rx_valid; next full frame with 0x81 -> rx_valid with 0x81, idx 0.
//  T6: 0x55 sent with cs_n high throughout -> no rx_valid, no frame_done, no error flags.

Source files
------------

// File: rtl/spi_peripheral_ht16d35a_rx_if.sv
// Bus bundle between a 3-wire SPI write controller and the HT16D35A receive model.
//   sck, dio, cs_n : SPI pins driven by the controller
//   err_clear      : clears the sticky error flags
//   rx_*           : per-byte report (data, one-cycle valid pulse, byte position)
//   frame_*        : end-of-frame pulse and number of complete bytes
//   *_err          : sticky timing / framing error flags
interface spi_peripheral_ht16d35a_rx_if #(
    parameter int unsigned MAX_BYTES = 8
);
    localparam int unsigned CW = $clog2(MAX_BYTES + 1);

    logic          sck;
    logic          dio;
    logic          cs_n;
    logic          err_clear;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [CW-1:0] rx_index;
    logic          frame_done;
    logic [CW-1:0] frame_count;
    logic          gap_err;
    logic          partial_err;
    logic          overrun_err;

    // Controller / host side
    modport master (
        output sck, dio, cs_n, err_clear,
        input  rx_data, rx_valid, rx_index, frame_done, frame_count,
        input  gap_err, partial_err, overrun_err
    );

    // Receiver side
    modport slave (
        input  sck, dio, cs_n, err_clear,
        output rx_data, rx_valid, rx_index, frame_done, frame_count,
        output gap_err, partial_err, overrun_err
    );
endinterface

// File: rtl/spi_peripheral_ht16d35a_rx.sv
// Receive-side model of the HT16D35A 3-wire SPI target (write-only).
// Oversamples sck/dio/cs_n on clk, rebuilds MSB-first bytes, reports each byte,
// frame ends, and sticky gap / partial-byte / overrun errors.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : slave modport of spi_peripheral_ht16d35a_rx_if (SPI pins in, reports out)
module spi_peripheral_ht16d35a_rx #(
    parameter int unsigned MAX_BYTES   = 8,
    parameter int unsigned CLK_2us     = 100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    spi_peripheral_ht16d35a_rx_if.slave  bus
);
    localparam int unsigned CW = $clog2(MAX_BYTES + 1);
    localparam int unsigned GW = $clog2(CLK_2us + 1);
    localparam int unsigned SW = $clog2(SYNC_STAGES + 2);

    typedef enum logic [1:0] {
        S_WAIT_CS_HIGH,
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_e;

    state_e                 state_q,       state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q,    sck_sync_d;
    logic [SYNC_STAGES-1:0] dio_sync_q,    dio_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,     cs_sync_d;
    logic                   sck_prev_q,    sck_prev_d;
    logic                   cs_dly_q,      cs_dly_d;
    logic [SW-1:0]          settle_q,      settle_d;
    logic [7:0]             shreg_q,       shreg_d;
    logic [3:0]             bit_cnt_q,     bit_cnt_d;
    logic [CW-1:0]          byte_idx_q,    byte_idx_d;
    logic [GW-1:0]          gap_cnt_q,     gap_cnt_d;
    logic [7:0]             rx_data_q,     rx_data_d;
    logic                   rx_valid_q,    rx_valid_d;
    logic [CW-1:0]          rx_index_q,    rx_index_d;
    logic                   frame_done_q,  frame_done_d;
    logic [CW-1:0]          frame_count_q, frame_count_d;
    logic                   gap_err_q,     gap_err_d;
    logic                   partial_err_q, partial_err_d;
    logic                   overrun_err_q, overrun_err_d;

    logic sck_s_c, dio_s_c, cs_s_c;
    logic sck_rise_c, sck_fall_c;
    logic gap_set_c, partial_set_c, overrun_set_c;

    assign sck_s_c    = sck_sync_q[SYNC_STAGES-1];
    assign dio_s_c    = dio_sync_q[SYNC_STAGES-1];
    assign cs_s_c     = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise_c = sck_s_c & ~sck_prev_q;
    assign sck_fall_c = ~sck_s_c & sck_prev_q;

    // Next-state, datapath and report logic
    always_comb begin
        state_d       = state_q;
        sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
        dio_sync_d    = {dio_sync_q[SYNC_STAGES-2:0], bus.dio};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
        sck_prev_d    = sck_s_c;
        // cs_n is looked at one cycle after sck so a byte finishing together
        // with the CS release is reported before the frame end
        cs_dly_d      = cs_s_c;
        settle_d      = settle_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        byte_idx_d    = byte_idx_q;
        gap_cnt_d     = gap_cnt_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_index_d    = rx_index_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        gap_set_c     = 1'b0;
        partial_set_c = 1'b0;
        overrun_set_c = 1'b0;

        // Synchronisers come out of reset preset high; ignore cs_n until flushed
        if (settle_q != SW'(SYNC_STAGES + 1)) begin
            settle_d = settle_q + SW'(1);
        end

        case (state_q)
            S_WAIT_CS_HIGH: begin
                if ((settle_q == SW'(SYNC_STAGES + 1)) && cs_dly_q) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (!cs_dly_q) begin
                    state_d    = S_SHIFT;
                    bit_cnt_d  = 4'd0;
                    byte_idx_d = '0;
                    gap_cnt_d  = '0;
                end
            end

            S_SHIFT: begin
                if (bit_cnt_q == 4'd8) begin
                    // Byte complete: report it, then time the inter-byte gap
                    rx_data_d  = shreg_q;
                    rx_valid_d = 1'b1;
                    rx_index_d = byte_idx_q;
                    if (byte_idx_q == CW'(MAX_BYTES)) begin
                        overrun_set_c = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + CW'(1);
                    end
                    bit_cnt_d = 4'd0;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else if (cs_dly_q) begin
                    if (bit_cnt_q != 4'd0) begin
                        partial_set_c = 1'b1;
                    end
                    bit_cnt_d     = 4'd0;
                    frame_done_d  = 1'b1;
                    frame_count_d = byte_idx_q;
                    state_d       = S_IDLE;
                end else if (sck_rise_c) begin
                    shreg_d   = {shreg_q[6:0], dio_s_c};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end

            S_GAP: begin
                if (gap_cnt_q != GW'(CLK_2us)) begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
                if (cs_dly_q) begin
                    if (gap_cnt_q < GW'(CLK_2us)) begin
                        gap_set_c = 1'b1;
                    end
                    frame_done_d  = 1'b1;
                    frame_count_d = byte_idx_q;
                    state_d       = S_IDLE;
                end else if (sck_fall_c) begin
                    if (gap_cnt_q < GW'(CLK_2us)) begin
                        gap_set_c = 1'b1;
                    end
                    state_d = S_SHIFT;
                end
            end

            default: state_d = S_WAIT_CS_HIGH;
        endcase

        // Sticky flags: a set in the same cycle as err_clear wins
        gap_err_d     = gap_set_c     | (gap_err_q     & ~bus.err_clear);
        partial_err_d = partial_set_c | (partial_err_q & ~bus.err_clear);
        overrun_err_d = overrun_set_c | (overrun_err_q & ~bus.err_clear);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_WAIT_CS_HIGH;
            sck_sync_q    <= '1;
            dio_sync_q    <= '1;
            cs_sync_q     <= '1;
            sck_prev_q    <= 1'b1;
            cs_dly_q      <= 1'b1;
            settle_q      <= '0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            byte_idx_q    <= '0;
            gap_cnt_q     <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_index_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            gap_err_q     <= 1'b0;
            partial_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sck_sync_q    <= sck_sync_d;
            dio_sync_q    <= dio_sync_d;
            cs_sync_q     <= cs_sync_d;
            sck_prev_q    <= sck_prev_d;
            cs_dly_q      <= cs_dly_d;
            settle_q      <= settle_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_idx_q    <= byte_idx_d;
            gap_cnt_q     <= gap_cnt_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_index_q    <= rx_index_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            gap_err_q     <= gap_err_d;
            partial_err_q <= partial_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_index    = rx_index_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_count = frame_count_q;
    assign bus.gap_err     = gap_err_q;
    assign bus.partial_err = partial_err_q;
    assign bus.overrun_err = overrun_err_q;

endmodule
